// File: rtl/shift_add_multiplier.sv
// Unsigned radix-2 shift-and-add multiplier; one carry-lookahead add per iteration cycle.
// Latency: START accept edge to DONE cycle is WIDTH+1 edges; one result per WIDTH+1 cycles back-to-back.
// Backpressure: START is sampled only while BUSY=0 (IDLE or FIN); requests while BUSY are ignored.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset, priority over all other inputs
//   START request, accepted in IDLE or in the FIN (DONE) cycle
//   A, B  multiplicand / multiplier, captured on the accepting edge
//   BUSY  high while iterations are running
//   DONE  one-cycle pulse when P holds a fresh product
//   P     product register, holds the last result until the next completion or reset
//
// WIDTH must be a multiple of 4: the adder is built from 4-bit lookahead groups.

module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [3:0]       gg;
    logic [3:0]       pp;
    logic [4:0]       cc;
    logic             carry;

    assign g = a & b;
    assign p = a ^ b;

    // Full lookahead inside each 4-bit group; group carries ripple between groups.
    // Computed in one process so the carry chain is a plain sequential walk.
    always_comb begin
        gg    = '0;
        pp    = '0;
        cc    = '0;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < NG; i++) begin
            gg    = g[4*i +: 4];
            pp    = p[4*i +: 4];
            cc[0] = carry;
            cc[1] = gg[0] | (pp[0] & cc[0]);
            cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
            cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & cc[0]);
            cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0])
                  | (pp[3] & pp[2] & pp[1] & pp[0] & cc[0]);
            sum[4*i +: 4] = pp ^ cc[3:0];
            carry = cc[4];
        end
        cout = carry;
    end
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] P
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last_iter;

    logic [WIDTH-1:0]  m_reg;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  q_reg;
    logic [CW-1:0]     count;
    logic [2*WIDTH-1:0] p_reg;

    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  sum;
    logic              carry;

    // Adding zero when Q[0]=0 yields {0, ACC}, so the adder is always in the path.
    assign addend = q_reg[0] ? m_reg : '0;

    cla_adder #(.WIDTH(WIDTH)) u_cla (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    assign last_iter = (count == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                BUSY = 1'b1;
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                DONE = 1'b1;
                // A new request in the DONE cycle starts immediately.
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            m_reg <= '0;
            acc   <= '0;
            q_reg <= '0;
            count <= '0;
            p_reg <= '0;
        end else if (accept) begin
            m_reg <= A;
            q_reg <= B;
            acc   <= '0;
            count <= '0;
        end else if (state == CALC) begin
            // {carry, sum, Q} shifted right by one: carry becomes ACC's MSB.
            acc   <= {carry, sum[WIDTH-1:1]};
            q_reg <= {sum[0], q_reg[WIDTH-1:1]};
            count <= count + CW'(1);
            if (last_iter) begin
                p_reg <= {carry, sum, q_reg[WIDTH-1:1]};
            end
        end
    end

    assign P = p_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    logic        rst8;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(4)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .A     (a),
        .B     (b),
        .BUSY  (busy),
        .DONE  (done),
        .P     (p)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .CLK   (clk),
        .RST   (rst8),
        .START (start8),
        .A     (a8),
        .B     (b8),
        .BUSY  (busy8),
        .DONE  (done8),
        .P     (p8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle (or in its DONE cycle); returns at the
    // negedge of the DONE cycle.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] expv, input string tag);
        logic [7:0] p_before;
        int n;
        int busy_n;
        int overlap;
        p_before = p;
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_n = busy ? 1 : 0;
        overlap = 0;
        check({tag, "_p_hold"}, 32'(p), 32'(p_before));
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (busy && done) overlap++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, "_p"}, 32'(p), 32'(expv));
        check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        if (done) done_count++;
    endtask

    initial begin
        int last_done;
        int dones;
        int n;

        rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'hF;
        rst8 = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        done_count = 0;

        // Reset held two cycles with START asserted: nothing may start.
        repeat (2) @(negedge clk);
        check("rst_p", 32'(p), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_p", 32'(p), 32'h00);

        // Directed products.
        run_op(4'hF, 4'hF, 8'hE1, "f_x_f");
        @(negedge clk);
        run_op(4'h9, 4'hF, 8'h87, "9_x_f");
        @(negedge clk);
        run_op(4'h0, 4'h7, 8'h00, "0_x_7");
        @(negedge clk);
        run_op(4'h1, 4'h1, 8'h01, "1_x_1");
        @(negedge clk);
        check("idle_after_ops_busy", 32'(busy), 32'd0);
        check("idle_after_ops_done", 32'(done), 32'd0);

        // START held high: re-accept in every DONE cycle, period 5; mid-op operand
        // changes must not leak into the running operation.
        a = 4'h3; b = 4'h5; start = 1'b1;
        last_done = -1;
        dones = 0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1) begin a = 4'h0; b = 4'h0; end
            if (t == 3) begin a = 4'h3; b = 4'h5; end
            if (busy && done) check("held_overlap", 32'd1, 32'd0);
            if (done) begin
                dones++;
                check("held_p", 32'(p), 32'h0F);
                if (last_done >= 0) check("held_period", 32'(t - last_done), 32'd5);
                last_done = t;
            end
        end
        check("held_done_count", 32'(dones), 32'd3);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("held_drain_busy", 32'(busy), 32'd0);

        // Reset in the second CALC cycle aborts with no DONE and clears P.
        a = 4'hF; b = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", 32'(p), 32'h00);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(4'h2, 4'h7, 8'h0E, "2_x_7");
        @(negedge clk);

        // Exhaustive 4-bit sweep.
        done_count = 0;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] ai;
            logic [3:0] bi;
            ai = i[7:4];
            bi = i[3:0];
            run_op(ai, bi, 8'(ai) * 8'(bi), "sweep");
        end
        check("sweep_done_count", 32'(done_count), 32'd256);
        @(negedge clk);

        // 8-bit instance: 0xFF * 0xFF = 0xFE01 after 9 edges.
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", 32'(n), 32'd9);
        check("w8_p", 32'(p8), 32'hFE01);
        check("w8_busy", 32'(busy8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
